display_scanner: RTL

Consumes the six BCD digits produced by the watch mode FSM (clock or stopwatch view) and drives a time-multiplexed, 6-digit, common-anode seven-segment display. Once per frame it captures a snapshot of all six digits so a refresh never shows a mix of old and new time. It then scans the digits one at a time, with anti-ghosting blanking and a blinking colon dot. It sits between the mode FSM outputs and the board pins.

---
 rtl/display_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/display_scanner.sv
// Six-digit multiplexed seven-segment scanner with per-frame snapshot, blanking and colon blink.
// Optional build macro LEADING_ZERO_BLANK_EN darkens digit 5 when the hours tens digit is zero.
module display_scanner #(
   parameter int unsigned SCAN_DIV     = 50000,
   parameter int unsigned BLANK_CYCLES = 2,
   parameter int unsigned BLINK_FRAMES = 83
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] s_unidade,
   input  logic [3:0] s_dezena,
   input  logic [3:0] m_unidade,
   input  logic [3:0] m_dezena,
   input  logic [3:0] h_unidade,
   input  logic [3:0] h_dezena,
   output logic [5:0] an,
   output logic [6:0] seg,
   output logic       dp,
   output logic       frame_start
);

   localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);

   logic [PW-1:0] p_q;
   logic [2:0]    i_q;
   logic [23:0]   snap_q;
   logic [FW-1:0] frame_cnt_q;
   logic          blink_q;

   logic          tick;
   logic          blank;
   logic          dark;
   logic [3:0]    digit;
   logic [5:0]    an_d;
   logic [6:0]    seg_d;
   logic          dp_d;

   function automatic logic [6:0] decode(input logic [3:0] d);
      logic [6:0] s;
      unique case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h3F;
      endcase
      return s;
   endfunction

   assign tick  = (p_q == PW'(SCAN_DIV - 1));
   assign blank = (p_q < PW'(BLANK_CYCLES));

   always_comb begin
      digit = 4'd0;
      case (i_q)
         3'd0:    digit = snap_q[3:0];
         3'd1:    digit = snap_q[7:4];
         3'd2:    digit = snap_q[11:8];
         3'd3:    digit = snap_q[15:12];
         3'd4:    digit = snap_q[19:16];
         3'd5:    digit = snap_q[23:20];
         default: digit = 4'd0;
      endcase
   end

`ifdef LEADING_ZERO_BLANK_EN
   assign dark = (i_q == 3'd5) && (snap_q[23:20] == 4'd0);
`else
   assign dark = 1'b0;
`endif

   always_comb begin
      an_d  = 6'h3F;
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      if (!blank && !dark) begin
         an_d  = ~(6'b1 << i_q);
         seg_d = decode(digit);
         // Colon dots sit on the minutes-units and hours-units digits.
         dp_d  = ~(blink_q && ((i_q == 3'd2) || (i_q == 3'd4)));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         p_q         <= '0;
         i_q         <= '0;
         snap_q      <= '0;
         frame_cnt_q <= '0;
         blink_q     <= 1'b0;
         an          <= 6'h3F;
         seg         <= 7'h7F;
         dp          <= 1'b1;
         frame_start <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (tick) begin
            p_q <= '0;
            if (i_q == 3'd5) begin
               i_q         <= '0;
               snap_q      <= {h_dezena, h_unidade, m_dezena, m_unidade, s_dezena, s_unidade};
               frame_start <= 1'b1;
               if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                  frame_cnt_q <= '0;
                  blink_q     <= ~blink_q;
               end else begin
                  frame_cnt_q <= frame_cnt_q + 1'b1;
               end
            end else begin
               i_q <= i_q + 3'd1;
            end
         end else begin
            p_q <= p_q + 1'b1;
         end
         an  <= an_d;
         seg <= seg_d;
         dp  <= dp_d;
      end
   end

endmodule
